// File: rtl/rf_bist_ctrl_if.sv
// rf_bist_ctrl_if -- bus bundle between the register-file BIST controller and
// its environment (register file port plus test control/status).
//
// Parameters: MEM_WIDTH (data width), MEM_DEPTH (locations), AW (address width).
// Signals:
//   Start   test request into the controller
//   RdData  register file read data, valid the cycle after RdEn
//   WrEn, RdEn, Address, WrData   register file access port
//   Busy, Done, Pass              test status
// Modports: master = controller side, slave = register file / test host side.
interface rf_bist_ctrl_if #(
   parameter int MEM_WIDTH = 16,
   parameter int MEM_DEPTH = 8,
   localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1
) ();
   logic                 Start;
   logic [MEM_WIDTH-1:0] RdData;
   logic                 WrEn;
   logic                 RdEn;
   logic [AW-1:0]        Address;
   logic [MEM_WIDTH-1:0] WrData;
   logic                 Busy;
   logic                 Done;
   logic                 Pass;

   modport master (
      input  Start, RdData,
      output WrEn, RdEn, Address, WrData, Busy, Done, Pass
   );

   modport slave (
      output Start, RdData,
      input  WrEn, RdEn, Address, WrData, Busy, Done, Pass
   );
endinterface

// File: rtl/rf_bist_ctrl.sv
// rf_bist_ctrl -- checkerboard BIST controller for a small register file.
//
// Runs two passes over the register file. Each pass writes every location
// (ascending), then reads each one back and compares it with the expected
// checkerboard value. Pass 0 uses P (alternating bits, bit0=1) at even
// addresses and ~P at odd addresses; pass 1 uses the inverse. The first
// mismatch aborts the test with Pass=0.
//
// Ports:
//   CLK        clock, rising edge
//   RST_n      asynchronous active-low reset
//   bus        rf_bist_ctrl_if.master: Start/RdData in; WrEn, RdEn, Address,
//              WrData, Busy, Done, Pass out (all registered)
//   Fail_Addr  address of the first mismatch   (only with BIST_ERR_CAPTURE_EN)
//   Fail_Data  read data of the first mismatch (only with BIST_ERR_CAPTURE_EN)
//
// Optional feature: define BIST_ERR_CAPTURE_EN to add the failure capture
// outputs. Without it those ports and registers do not exist.
module rf_bist_ctrl #(
   parameter int MEM_WIDTH = 16,
   parameter int MEM_DEPTH = 8,
   localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1
) (
   input  logic                 CLK,
   input  logic                 RST_n,
   rf_bist_ctrl_if.master       bus
`ifdef BIST_ERR_CAPTURE_EN
   ,
   output logic [AW-1:0]        Fail_Addr,
   output logic [MEM_WIDTH-1:0] Fail_Data
`endif
);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      WR   = 3'd1,
      RD   = 3'd2,
      CHK  = 3'd3,
      DONE = 3'd4
   } state_t;

   localparam logic [AW-1:0] LAST_ADDR = AW'(MEM_DEPTH - 1);

   // Base pattern: ones on even bit positions (16'h5555 for width 16).
   function automatic logic [MEM_WIDTH-1:0] alt_pat();
      logic [MEM_WIDTH-1:0] p;
      p = '0;
      for (int i = 0; i < MEM_WIDTH; i += 2) p[i] = 1'b1;
      return p;
   endfunction

   localparam logic [MEM_WIDTH-1:0] PAT = alt_pat();

   // Checkerboard value for a location: odd addresses and pass 1 each invert.
   function automatic logic [MEM_WIDTH-1:0] cb_val(input logic pass_sel,
                                                   input logic [AW-1:0] addr);
      return (pass_sel ^ addr[0]) ? ~PAT : PAT;
   endfunction

   state_t state;
   logic   pass_sel;
   // Set for the cycle between accepting Start and the first write, so the
   // test begins one edge after the Start sample.
   logic   go;

   always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) begin
         state       <= IDLE;
         go          <= 1'b0;
         pass_sel    <= 1'b0;
         bus.WrEn    <= 1'b0;
         bus.RdEn    <= 1'b0;
         bus.Address <= '0;
         bus.WrData  <= '0;
         bus.Busy    <= 1'b0;
         bus.Done    <= 1'b0;
         bus.Pass    <= 1'b0;
`ifdef BIST_ERR_CAPTURE_EN
         Fail_Addr   <= '0;
         Fail_Data   <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (go) begin
                  go          <= 1'b0;
                  state       <= WR;
                  bus.WrEn    <= 1'b1;
                  bus.Address <= '0;
                  bus.WrData  <= cb_val(1'b0, '0);
                  bus.Busy    <= 1'b1;
               end else if (bus.Start) begin
                  // Accepting Start clears the previous result.
                  go       <= 1'b1;
                  pass_sel <= 1'b0;
                  bus.Pass <= 1'b0;
`ifdef BIST_ERR_CAPTURE_EN
                  Fail_Addr <= '0;
                  Fail_Data <= '0;
`endif
               end
            end

            WR: begin
               if (bus.Address == LAST_ADDR) begin
                  state       <= RD;
                  bus.WrEn    <= 1'b0;
                  bus.RdEn    <= 1'b1;
                  bus.Address <= '0;
               end else begin
                  bus.Address <= bus.Address + AW'(1);
                  bus.WrData  <= cb_val(pass_sel, bus.Address + AW'(1));
               end
            end

            // Single read strobe; data is compared in CHK.
            RD: begin
               state    <= CHK;
               bus.RdEn <= 1'b0;
            end

            CHK: begin
               if (bus.RdData != cb_val(pass_sel, bus.Address)) begin
                  state    <= DONE;
                  bus.Done <= 1'b1;
                  bus.Busy <= 1'b0;
                  bus.Pass <= 1'b0;
`ifdef BIST_ERR_CAPTURE_EN
                  Fail_Addr <= bus.Address;
                  Fail_Data <= bus.RdData;
`endif
               end else if (bus.Address != LAST_ADDR) begin
                  state       <= RD;
                  bus.RdEn    <= 1'b1;
                  bus.Address <= bus.Address + AW'(1);
               end else if (!pass_sel) begin
                  // End of pass 0: rewrite everything with the inverse.
                  pass_sel    <= 1'b1;
                  state       <= WR;
                  bus.WrEn    <= 1'b1;
                  bus.Address <= '0;
                  bus.WrData  <= cb_val(1'b1, '0);
               end else begin
                  state    <= DONE;
                  bus.Done <= 1'b1;
                  bus.Busy <= 1'b0;
                  bus.Pass <= 1'b1;
               end
            end

            DONE: begin
               state    <= IDLE;
               bus.Done <= 1'b0;
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rf_bist_ctrl.sv
// tb_rf_bist_ctrl -- scoreboard bench for rf_bist_ctrl.
// A register file model with per-address stuck-at masks answers the DUT.
// For each run a reference model predicts the write stream, the read stream
// and the final result; a monitor pops and compares as the DUT presents them.
module tb_rf_bist_ctrl;
   localparam int W  = 16;
   localparam int D  = 8;
   localparam int AW = $clog2(D);

   logic CLK   = 1'b0;
   logic RST_n = 1'b0;
   always #5 CLK = ~CLK;

   rf_bist_ctrl_if #(.MEM_WIDTH(W), .MEM_DEPTH(D)) bus ();

`ifdef BIST_ERR_CAPTURE_EN
   logic [AW-1:0] Fail_Addr;
   logic [W-1:0]  Fail_Data;
`endif

   rf_bist_ctrl #(.MEM_WIDTH(W), .MEM_DEPTH(D)) dut (
      .CLK       (CLK),
      .RST_n     (RST_n),
      .bus       (bus)
`ifdef BIST_ERR_CAPTURE_EN
      ,
      .Fail_Addr (Fail_Addr),
      .Fail_Data (Fail_Data)
`endif
   );

   // ---------------- register file model with stuck-at faults -------------
   logic [W-1:0] mem [D];
   logic [W-1:0] sa0 [D];
   logic [W-1:0] sa1 [D];

   always @(posedge CLK) begin
      if (bus.WrEn) mem[bus.Address] <= (bus.WrData & ~sa0[bus.Address]) | sa1[bus.Address];
      if (bus.RdEn) bus.RdData <= mem[bus.Address];
   end

   // ---------------- bookkeeping ------------------------------------------
   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   typedef struct {
      int           addr;
      logic [W-1:0] data;
   } acc_t;

   typedef struct {
      int           done_cyc;
      bit           ok;
      int           faddr;
      logic [W-1:0] fdata;
   } res_t;

   acc_t wq[$];
   int   rq[$];
   res_t resq[$];

   // ---------------- reference model --------------------------------------
   function automatic logic [W-1:0] expect_val(input int pass, input int addr);
      logic [W-1:0] p;
      for (int i = 0; i < W; i++) p[i] = (i % 2 == 0);
      return ((pass + addr) % 2 == 0) ? p : ~p;
   endfunction

   // Walks the test algorithm: per pass, write all, then read/compare each.
   // Each write costs one cycle, each read two; Done follows the last one.
   task automatic predict(input int start_cyc, output res_t r);
      logic [W-1:0] stored [D];
      int  k;
      bit  failed;
      acc_t a_e;
      k = 0;
      failed = 0;
      r.ok = 1; r.faddr = 0; r.fdata = '0;
      for (int p = 0; p < 2 && !failed; p++) begin
         for (int a = 0; a < D; a++) begin
            k++;
            a_e.addr = a;
            a_e.data = expect_val(p, a);
            wq.push_back(a_e);
            stored[a] = (a_e.data & ~sa0[a]) | sa1[a];
         end
         for (int a = 0; a < D && !failed; a++) begin
            k += 2;
            rq.push_back(a);
            if (stored[a] != expect_val(p, a)) begin
               failed  = 1;
               r.ok    = 0;
               r.faddr = a;
               r.fdata = stored[a];
            end
         end
      end
      r.done_cyc = start_cyc + k + 1;
      resq.push_back(r);
   endtask

   // ---------------- monitor ----------------------------------------------
   always @(negedge CLK) begin
      if (RST_n) begin
         check("rw_exclusive", {63'd0, bus.WrEn & bus.RdEn}, 64'd0);
         check("addr_range", {63'd0, (int'(bus.Address) < D)}, 64'd1);
         if (bus.WrEn) begin
            if (wq.size() == 0) check("unexpected_write", 64'd1, 64'd0);
            else begin
               acc_t e;
               e = wq.pop_front();
               check("wr_addr", 64'(bus.Address), 64'(e.addr));
               check("wr_data", 64'(bus.WrData), 64'(e.data));
            end
         end
         if (bus.RdEn) begin
            if (rq.size() == 0) check("unexpected_read", 64'd1, 64'd0);
            else check("rd_addr", 64'(bus.Address), 64'(rq.pop_front()));
         end
         if (bus.Done) begin
            if (resq.size() == 0) check("unexpected_done", 64'd1, 64'd0);
            else begin
               res_t r;
               r = resq.pop_front();
               check("done_cycle", 64'(cyc), 64'(r.done_cyc));
               check("pass_result", 64'(bus.Pass), 64'(r.ok));
               check("busy_at_done", 64'(bus.Busy), 64'd0);
               check("no_wr_at_done", 64'(bus.WrEn | bus.RdEn), 64'd0);
`ifdef BIST_ERR_CAPTURE_EN
               check("fail_addr", 64'(Fail_Addr), 64'(r.faddr));
               check("fail_data", 64'(Fail_Data), 64'(r.fdata));
`endif
            end
         end
      end
   end

   // ---------------- stimulus ---------------------------------------------
   task automatic clear_faults();
      for (int a = 0; a < D; a++) begin
         sa0[a] = '0;
         sa1[a] = '0;
      end
   endtask

   task automatic check_all_zero(input string nm);
      check({nm, "_wren"},   64'(bus.WrEn),    64'd0);
      check({nm, "_rden"},   64'(bus.RdEn),    64'd0);
      check({nm, "_addr"},   64'(bus.Address), 64'd0);
      check({nm, "_wrdata"}, 64'(bus.WrData),  64'd0);
      check({nm, "_busy"},   64'(bus.Busy),    64'd0);
      check({nm, "_done"},   64'(bus.Done),    64'd0);
      check({nm, "_pass"},   64'(bus.Pass),    64'd0);
`ifdef BIST_ERR_CAPTURE_EN
      check({nm, "_faddr"},  64'(Fail_Addr),   64'd0);
      check({nm, "_fdata"},  64'(Fail_Data),   64'd0);
`endif
   endtask

   // One complete test. noise: random Start toggling while the test runs.
   // hold: Start stays high until Done is seen.
   task automatic run(input bit noise, input bit hold);
      res_t r;
      int   n;
      @(negedge CLK);
      predict(cyc + 1, r);
      bus.Start = 1'b1;
      @(negedge CLK);
      check("pass_cleared_on_start", 64'(bus.Pass), 64'd0);
`ifdef BIST_ERR_CAPTURE_EN
      check("faddr_cleared_on_start", 64'(Fail_Addr), 64'd0);
      check("fdata_cleared_on_start", 64'(Fail_Data), 64'd0);
`endif
      bus.Start = hold;
      n = 0;
      do begin
         @(negedge CLK);
         n++;
         if (noise && !hold && !bus.Done) bus.Start = 1'($urandom_range(0, 1));
      end while (!bus.Done && n < 200);
      if (n >= 200) check("done_timeout", 64'd1, 64'd0);
      bus.Start = 1'b0;
      repeat (4) @(negedge CLK);
      check("pass_sticky", 64'(bus.Pass), 64'(r.ok));
      check("idle_busy", 64'(bus.Busy), 64'd0);
      check("idle_done", 64'(bus.Done), 64'd0);
   endtask

   initial begin
      bus.Start = 1'b0;
      clear_faults();
      #1;
      check_all_zero("reset");
      repeat (3) @(negedge CLK);
      RST_n = 1'b1;
      repeat (3) @(negedge CLK);
      check_all_zero("idle_after_reset");

      // Fault-free run.
      run(0, 0);

      // Bit0 stuck-at-0 at address 3: only the pass-1 value 5555 exposes it.
      sa0[3] = 16'h0001;
      run(0, 0);
      clear_faults();

      // Back to back: bit0 stuck-at-1 at address 3 (fails in pass 0),
      // then a fault-free run that must clear the captured failure.
      sa1[3] = 16'h0001;
      run(0, 0);
      clear_faults();
      run(0, 0);

      // Start held high for the whole run: exactly one test.
      run(0, 1);

      // Reset in the middle of a pass-1 read.
      begin
         res_t r;
         @(negedge CLK);
         predict(cyc + 1, r);
         bus.Start = 1'b1;
         @(negedge CLK);
         bus.Start = 1'b0;
         repeat (35) @(negedge CLK);
         check("rden_before_reset", 64'(bus.RdEn), 64'd1);
         #2;
         RST_n = 1'b0;
         wq.delete();
         rq.delete();
         resq.delete();
         #1;
         check_all_zero("async_reset");
         repeat (2) @(negedge CLK);
         RST_n = 1'b1;
         repeat (3) @(negedge CLK);
         check_all_zero("stay_idle");
         run(0, 0);
      end

      // Randomized runs with random single-bit stuck faults and Start noise.
      for (int it = 0; it < 10; it++) begin
         clear_faults();
         if ($urandom_range(0, 2) != 0) begin
            int a;
            int b;
            a = $urandom_range(0, D - 1);
            b = $urandom_range(0, W - 1);
            if ($urandom_range(0, 1) != 0) sa0[a][b] = 1'b1;
            else                           sa1[a][b] = 1'b1;
         end
         repeat ($urandom_range(0, 5)) @(negedge CLK);
         run(1, 0);
      end

      check("writes_drained",  64'(wq.size()),   64'd0);
      check("reads_drained",   64'(rq.size()),   64'd0);
      check("results_drained", 64'(resq.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Absolute guard so the run always ends.
   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end
endmodule
